// File: rtl/scroll_sequencer.sv
// Step/direction sequencer for the scrolling word display: IDLE/RUN/PAUSED FSM, step divider, wrap and bounce modes.
// Optional blinking blank while paused is enabled by defining SCROLL_BLINK_EN.
module scroll_sequencer #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int N_POS     = 4,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                       CLOCK_50,
  input  logic                       aclr,
  input  logic                       start,
  input  logic                       pause,
  input  logic                       stop,
  input  logic                       dir_req,
  input  logic                       bounce,
  output logic [$clog2(N_POS)-1:0]   step,
  output logic                       dir,
  output logic                       tick,
  output logic                       running,
  output logic                       blank
);

  localparam int W  = $clog2(N_POS);
  localparam int CW = $clog2(TICK_DIV);

  localparam logic [W-1:0]  STEP_MAX = W'(N_POS - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [W-1:0]    step_n;
  logic            dir_n;
  logic            tick_n;

  function automatic logic [W-1:0] wrap_next(input logic [W-1:0] s, input logic up);
    logic [W-1:0] ns;
    if (up) ns = (s == STEP_MAX) ? '0 : s + 1'b1;
    else    ns = (s == '0) ? STEP_MAX : s - 1'b1;
    return ns;
  endfunction

  // Returns {dir, step}; dir flips on arrival at either end so it shows the direction of the next move.
  function automatic logic [W:0] bounce_next(input logic [W-1:0] s, input logic d);
    logic [W-1:0] ns;
    logic         nd;
    if (d && s == STEP_MAX) begin
      ns = STEP_MAX - 1'b1;
      nd = 1'b0;
    end else if (!d && s == '0) begin
      ns = W'(1);
      nd = 1'b1;
    end else if (d) begin
      ns = s + 1'b1;
      nd = (ns != STEP_MAX);
    end else begin
      ns = s - 1'b1;
      nd = (ns == '0);
    end
    return {nd, ns};
  endfunction

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    step_n  = step;
    dir_n   = dir;
    tick_n  = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n  = '0;
        step_n = '0;
        dir_n  = dir_req;
        if (!stop && start) state_n = S_RUN;
      end
      S_RUN: begin
        if (stop) begin
          state_n = S_IDLE;
          cnt_n   = '0;
          step_n  = '0;
        end else if (pause) begin
          state_n = S_PAUSED;
        end else if (cnt == CNT_MAX) begin
          cnt_n  = '0;
          tick_n = 1'b1;
          if (bounce) begin
            {dir_n, step_n} = bounce_next(step, dir);
          end else begin
            dir_n  = dir_req;
            step_n = wrap_next(step, dir_req);
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_PAUSED: begin
        if (stop) begin
          state_n = S_IDLE;
          cnt_n   = '0;
          step_n  = '0;
        end else if (start) begin
          state_n = S_RUN;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        step_n  = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!aclr) begin
      state   <= S_IDLE;
      cnt     <= '0;
      step    <= '0;
      dir     <= 1'b1;
      tick    <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      step    <= step_n;
      dir     <= dir_n;
      tick    <= tick_n;
      running <= (state_n == S_RUN);
    end
  end

`ifdef SCROLL_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BCNT_MAX = BW'(BLINK_DIV - 1);

  logic [BW-1:0] bcnt;

  // Blink phase restarts on every entry to PAUSED and is cleared on any exit.
  always_ff @(posedge CLOCK_50) begin
    if (!aclr) begin
      bcnt  <= '0;
      blank <= 1'b0;
    end else if (state_n == S_PAUSED && state == S_PAUSED) begin
      if (bcnt == BCNT_MAX) begin
        bcnt  <= '0;
        blank <= ~blank;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end else begin
      bcnt  <= '0;
      blank <= 1'b0;
    end
  end
`else
  // BLINK_DIV >= 1, so this is a constant 0.
  assign blank = (BLINK_DIV < 1);
`endif

endmodule

// File: tb/tb_scroll_sequencer.sv
// Directed bench for scroll_sequencer with TICK_DIV=4, N_POS=4, BLINK_DIV=3; outputs sampled on the falling edge.
module tb_scroll_sequencer;

  localparam int TICK_DIV  = 4;
  localparam int N_POS     = 4;
  localparam int BLINK_DIV = 3;

  logic       CLOCK_50 = 1'b0;
  logic       aclr     = 1'b0;
  logic       start    = 1'b0;
  logic       pause    = 1'b0;
  logic       stop     = 1'b0;
  logic       dir_req  = 1'b1;
  logic       bounce   = 1'b0;
  logic [1:0] step;
  logic       dir;
  logic       tick;
  logic       running;
  logic       blank;

  int n_checks = 0;
  int n_fail   = 0;

  scroll_sequencer #(
    .TICK_DIV  (TICK_DIV),
    .N_POS     (N_POS),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .aclr     (aclr),
    .start    (start),
    .pause    (pause),
    .stop     (stop),
    .dir_req  (dir_req),
    .bounce   (bounce),
    .step     (step),
    .dir      (dir),
    .tick     (tick),
    .running  (running),
    .blank    (blank)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge CLOCK_50);
  endtask

  // n-1 quiet cycles then a tick carrying the expected step/dir.
  task automatic run_interval(input string tag, input int n, input int exp_step, input int exp_dir);
    for (int i = 1; i < n; i++) begin
      cyc();
      check_eq({tag, "_notick"}, int'(tick), 0);
    end
    cyc();
    check_eq({tag, "_tick"}, int'(tick), 1);
    check_eq({tag, "_step"}, int'(step), exp_step);
    check_eq({tag, "_dir"},  int'(dir),  exp_dir);
  endtask

  function automatic int exp_blank(input int k);
`ifdef SCROLL_BLINK_EN
    return (k / BLINK_DIV) % 2;
`else
    return (k < 0) ? 1 : 0;
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and idle state
    aclr = 1'b0;
    dir_req = 1'b0;
    cyc(); cyc();
    check_eq("rst_step", int'(step), 0);
    check_eq("rst_dir", int'(dir), 1);
    check_eq("rst_tick", int'(tick), 0);
    check_eq("rst_running", int'(running), 0);
    check_eq("rst_blank", int'(blank), 0);
    aclr = 1'b1;
    cyc();
    check_eq("idle_dir_follow0", int'(dir), 0);
    dir_req = 1'b1;
    cyc();
    check_eq("idle_dir_follow1", int'(dir), 1);

    // Wrap mode, incrementing
    start = 1'b1; cyc(); start = 1'b0;
    check_eq("wrap_running", int'(running), 1);
    check_eq("wrap_step0", int'(step), 0);
    check_eq("wrap_tick0", int'(tick), 0);
    for (int k = 1; k <= 5; k++) run_interval("wrap_up", TICK_DIV, k % N_POS, 1);

    // Direction change between ticks
    run_interval("wrap_to2", TICK_DIV, 2, 1);
    cyc();
    dir_req = 1'b0;
    cyc();
    check_eq("dirchg_held", int'(dir), 1);
    check_eq("dirchg_notick", int'(tick), 0);
    cyc();
    check_eq("dirchg_held2", int'(dir), 1);
    cyc();
    check_eq("dirchg_tick", int'(tick), 1);
    check_eq("dirchg_step", int'(step), 1);
    check_eq("dirchg_dir", int'(dir), 0);
    run_interval("wrap_dn0", TICK_DIV, 0, 0);
    run_interval("wrap_dn3", TICK_DIV, 3, 0);

    // stop together with start while running
    stop = 1'b1; start = 1'b1; cyc(); stop = 1'b0; start = 1'b0;
    check_eq("stopstart_running", int'(running), 0);
    check_eq("stopstart_step", int'(step), 0);
    check_eq("stopstart_tick", int'(tick), 0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      check_eq("idle_notick", int'(tick), 0);
      check_eq("idle_step", int'(step), 0);
    end

    // Bounce mode
    bounce = 1'b1;
    dir_req = 1'b1;
    cyc();
    start = 1'b1; cyc(); start = 1'b0;
    begin
      int bs[7] = '{1, 2, 3, 2, 1, 0, 1};
      int bd[7] = '{1, 1, 0, 0, 0, 1, 1};
      for (int k = 0; k < 7; k++) begin
        dir_req = ~dir_req;
        run_interval("bounce", TICK_DIV, bs[k], bd[k]);
      end
    end
    stop = 1'b1; cyc(); stop = 1'b0;
    bounce = 1'b0;
    dir_req = 1'b1;
    cyc();

    // Pause mid-interval and resume the remaining interval
    start = 1'b1; cyc(); start = 1'b0;
    run_interval("pre_pause", TICK_DIV, 1, 1);
    cyc(); cyc();
    pause = 1'b1; cyc(); pause = 1'b0;
    check_eq("paused_running", int'(running), 0);
    check_eq("paused_blank0", int'(blank), 0);
    for (int k = 1; k <= 10; k++) begin
      cyc();
      check_eq("paused_notick", int'(tick), 0);
      check_eq("paused_step", int'(step), 1);
      check_eq("paused_blank", int'(blank), exp_blank(k));
    end
    start = 1'b1; cyc(); start = 1'b0;
    check_eq("resume_running", int'(running), 1);
    check_eq("resume_blank", int'(blank), 0);
    run_interval("resume", 2, 2, 1);

    // pause together with start while running
    pause = 1'b1; start = 1'b1; cyc(); pause = 1'b0; start = 1'b0;
    check_eq("pausestart_running", int'(running), 0);
    check_eq("pausestart_step", int'(step), 2);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check_eq("pausestart_notick", int'(tick), 0);
    end
    start = 1'b1; cyc(); start = 1'b0;
    run_interval("pausestart_resume", TICK_DIV, 3, 1);

    // Reset mid-run at step 2, with start held during reset
    stop = 1'b1; cyc(); stop = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    run_interval("prerst1", TICK_DIV, 1, 1);
    run_interval("prerst2", TICK_DIV, 2, 1);
    cyc();
    aclr = 1'b0; start = 1'b1; dir_req = 1'b0;
    cyc(); cyc();
    check_eq("midrst_step", int'(step), 0);
    check_eq("midrst_dir", int'(dir), 1);
    check_eq("midrst_tick", int'(tick), 0);
    check_eq("midrst_running", int'(running), 0);
    check_eq("midrst_blank", int'(blank), 0);
    aclr = 1'b1; start = 1'b0;
    cyc();
    check_eq("postrst_running", int'(running), 0);
    check_eq("postrst_dir", int'(dir), 0);
    check_eq("postrst_step", int'(step), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
